// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit: size encodings, FSM states,
// and lane helpers.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Encoding 2'b11 falls through to the word case everywhere.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      default: bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response handshake of the load/store unit.
// master = pipeline (issues requests), slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and
// sub-word store merge into a previously read word.
module mau_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [3:0]  mask;
  logic [31:0] wrep;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign mask = lane_mask(size, offset);

  // Replicate store data so every candidate lane already holds it.
  always_comb begin
    case (size)
      SZ_BYTE: wrep = {4{wdata[7:0]}};
      SZ_HALF: wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rword[8*gi +: 8];
      assign merged[8*gi +: 8] = mask[gi] ? wrep[8*gi +: 8] : rword[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[offset];
  assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = rword;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit over a word-only data memory; sub-word stores use
// read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  state_e            state_reg, state_next;
  logic              write_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] wword_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              trap;
  logic              err_reg;

  assign accept = bus.req_valid && (state_reg == S_IDLE);

`ifdef MISALIGN_TRAP_EN
  assign trap = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (trap)                                    state_next = S_RESP;
          else if (bus.req_write && bus.req_size[1])   state_next = S_WR;
          else                                         state_next = S_RD;
        end
      end
      S_RD:    state_next = write_reg ? S_WR : S_RESP;
      S_WR:    state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields are latched once; inputs are ignored until back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg  <= 1'b0;
      size_reg   <= SZ_BYTE;
      signed_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wword_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      write_reg  <= bus.req_write;
      size_reg   <= bus.req_size;
      signed_reg <= bus.req_signed;
      addr_reg   <= bus.req_addr;
      wdata_reg  <= bus.req_wdata;
      wword_reg  <= bus.req_wdata;
      rdata_reg  <= '0;
      err_reg    <= trap;
    end else if (state_reg == S_RD) begin
      if (write_reg) wword_reg <= merged;
      else           rdata_reg <= load_data;
    end
  end

  mau_lane_align u_align (
    .size      (size_reg),
    .sign_ext  (signed_reg),
    .offset    (addr_reg[1:0]),
    .rword     (ReadData),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged)
  );

  assign MemRead   = (state_reg == S_RD);
  assign MemWrite  = (state_reg == S_WR);
  assign Address   = (MemRead || MemWrite) ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign WriteData = MemWrite ? wword_reg : '0;

  assign bus.req_ready = (state_reg == S_IDLE);
  assign bus.rsp_valid = (state_reg == S_RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? rdata_reg : '0;
  assign bus.rsp_err   = bus.rsp_valid & err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: mem_access_unit paired with a small word memory model,
// hand-computed expectations for loads, stores, reset abort and misalignment.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;
  int both_high = 0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write at posedge.
  assign ReadData = mem[Address[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (MemWrite) begin
      mem[Address[7:2]] <= WriteData;
    end
  end

  always @(negedge clk) if (MemRead && MemWrite) both_high <= both_high + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to its response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr, output int nbusy);
    rd = 0; er = 0; lat = 0; nrd = 0; nwr = 0; nbusy = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wdata = 32'h5A5A5A5A;
      lat++;
      if (MemRead) nrd++;
      if (MemWrite) nwr++;
      if (!bus.req_ready) nbusy++;
      if (bus.rsp_valid) begin
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        break;
      end
    end
    @(negedge clk);
    check("rsp_once", {31'b0, bus.rsp_valid}, 32'd0);
    $display("req w=%0b sz=%0d s=%0b a=0x%08h wd=0x%08h -> rd=0x%08h err=%0b lat=%0d rd#=%0d wr#=%0d",
             w, sz, sg, a, wd, rd, er, lat, nrd, nwr);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nrd, nwr, nbusy, seen;

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_memrw", {30'b0, MemRead, MemWrite}, 32'd0);
    check("rst_addr", Address, 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_rsp", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);

    do_req(0, 2'b00, 1, 32'h11, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lb11", rd, 32'hFFFFFFAA);
    check("lb11_lat", lat, 2);
    check("lb11_rd#", nrd, 1);
    check("lb11_wr#", nwr, 0);
    check("lb11_err", {31'b0, er}, 0);

    do_req(0, 2'b01, 0, 32'h12, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lhu12", rd, 32'h00008899);
    do_req(0, 2'b01, 1, 32'h12, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lh12", rd, 32'hFFFF8899);
    do_req(0, 2'b00, 0, 32'h10, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lbu10", rd, 32'h000000BB);
    do_req(0, 2'b00, 1, 32'h10, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lb10", rd, 32'hFFFFFFBB);

    do_req(1, 2'b00, 0, 32'h13, 32'h000000CC, rd, er, lat, nrd, nwr, nbusy);
    check("sb13_lat", lat, 3);
    check("sb13_rd#", nrd, 1);
    check("sb13_wr#", nwr, 1);
    check("sb13_rdata", rd, 32'h0);
    check("sb13_mem", mem[4], 32'hCC99AABB);

    do_req(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, rd, er, lat, nrd, nwr, nbusy);
    check("sw20_lat", lat, 2);
    check("sw20_rd#", nrd, 0);
    check("sw20_wr#", nwr, 1);
    check("sw20_busy", nbusy, 2);
    do_req(0, 2'b10, 0, 32'h20, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lw20", rd, 32'hDEADBEEF);

    do_req(0, 2'b10, 0, 32'h22, 0, rd, er, lat, nrd, nwr, nbusy);
`ifdef MISALIGN_TRAP_EN
    check("lw22_err", {31'b0, er}, 1);
    check("lw22_rdata", rd, 32'h0);
    check("lw22_rd#", nrd, 0);
    check("lw22_lat", lat, 1);
`else
    check("lw22_err", {31'b0, er}, 0);
    check("lw22_rdata", rd, 32'hDEADBEEF);
    check("lw22_rd#", nrd, 1);
`endif

    do_req(1, 2'b01, 0, 32'h22, 32'hFFFF1234, rd, er, lat, nrd, nwr, nbusy);
    check("sh22_mem", mem[8], 32'h1234BEEF);
    do_req(0, 2'b11, 0, 32'h10, 0, rd, er, lat, nrd, nwr, nbusy);
    check("lw11enc", rd, 32'hCC99AABB);
    do_req(1, 2'b00, 0, 32'h10, 32'h12345677, rd, er, lat, nrd, nwr, nbusy);
    check("sb10_mem", mem[4], 32'hCC99AA77);

    // Reset while the RD phase of a halfword store is in progress.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("shabort_inrd", {31'b0, MemRead}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("shabort_ready", {31'b0, bus.req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (MemWrite || bus.rsp_valid) seen++;
      @(negedge clk);
    end
    check("shabort_quiet", seen, 0);
    check("shabort_mem", mem[4], 32'hCC99AA77);
    $display("reset abort sh 0x10 -> mem[0x10]=0x%08h", mem[4]);

    check("rw_exclusive", both_high, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
